fxp_div_stream: RTL and testbench

Streaming signed fixed-point divider: `out = a / b`, with `WIDTH`-bit operands and results and `FBITS` fractional bits. It is the next generation of the team's iterative fixed-point divider and adds:
- a valid/ready handshake with a pass-through tag;
- `BPC` quotient bits per cycle;
- correct handling of most-negative operands;
- round-half-to-even;
- optional saturation.

It sits between accumulator outputs and the normalisation stage.

---
 rtl/fxp_div_stream_if.sv | 21 ++
 rtl/fxp_div_stream.sv | 108 ++++++++++
 tb/tb_fxp_div_stream.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fxp_div_stream_if.sv
// fxp_div_stream_if: request/result handshake bundle for fxp_div_stream.
interface fxp_div_stream_if #(
  parameter int WIDTH = 16,
  parameter int TAGW = 4
);
  logic in_valid, in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic [TAGW-1:0] in_tag;
  logic out_valid, out_ready;
  logic [WIDTH-1:0] out_val;
  logic [TAGW-1:0] out_tag;
  logic out_dbz, out_ovf, busy;
  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input in_ready, out_valid, out_val, out_tag, out_dbz, out_ovf, busy
  );
  modport slave (
    input in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_val, out_tag, out_dbz, out_ovf, busy
  );
endinterface

// File: rtl/fxp_div_stream.sv
// fxp_div_stream: streaming signed fixed-point divider, BPC quotient bits per cycle, round-half-to-even.
// Define FXP_DIV_SAT_EN to saturate on overflow and divide-by-zero instead of returning 0.
module fxp_div_stream #(
  parameter int WIDTH = 16,
  parameter int FBITS = 8,
  parameter int BPC = 1,
  parameter int TAGW = 4
) (
  input logic clk,
  input logic rst_n,
  fxp_div_stream_if.slave bus
);
  localparam int N = WIDTH + FBITS + 1;
  localparam int C = (N + BPC - 1) / BPC;
  localparam int P = C * BPC;
  localparam int CW = $clog2(C + 1);
  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [N-1:0] LIM = N'(MINV);
  typedef enum logic [1:0] {IDLE, CALC, ROUND, OUT} state_e;
  state_e state_q;
  logic [WIDTH-1:0] b_q, r_q, r_d, abs_a, abs_b, res, ovf_val, dbz_val;
  logic [P-1:0] qd_q, qd_d;
  logic [CW-1:0] cnt_q;
  logic [TAGW-1:0] tag_q;
  logic [WIDTH:0] t;
  logic [N-1:0] m;
  logic sign_q, ge, ovf, accept;
  assign bus.in_ready = state_q == IDLE || (state_q == OUT && bus.out_ready);
  assign bus.busy = state_q != IDLE;
  assign accept = bus.in_valid && bus.in_ready;
  assign abs_a = bus.in_a[WIDTH-1] ? -bus.in_a : bus.in_a;
  assign abs_b = bus.in_b[WIDTH-1] ? -bus.in_b : bus.in_b;
  // qd holds the remaining dividend bits on top and shifts quotient bits in at the bottom
  always_comb begin
    r_d = r_q;
    qd_d = qd_q;
    t = '0;
    ge = 1'b0;
    for (int i = 0; i < BPC; i++) begin
      t = {r_d, qd_d[P-1]};
      ge = t >= {1'b0, b_q};
      qd_d = {qd_d[P-2:0], ge};
      r_d = ge ? WIDTH'(t - {1'b0, b_q}) : t[WIDTH-1:0];
    end
  end
  assign m = {1'b0, qd_q[N-1:1]} + N'(qd_q[0] && (qd_q[1] || r_q != '0));
  assign ovf = sign_q ? m > LIM : m >= LIM;
  assign res = sign_q ? -m[WIDTH-1:0] : m[WIDTH-1:0];
`ifdef FXP_DIV_SAT_EN
  assign ovf_val = sign_q ? MINV : MAXV;
  assign dbz_val = bus.in_a[WIDTH-1] ? MINV : (|bus.in_a ? MAXV : '0);
`else
  assign ovf_val = '0;
  assign dbz_val = '0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      b_q <= '0;
      r_q <= '0;
      qd_q <= '0;
      cnt_q <= '0;
      tag_q <= '0;
      sign_q <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_val <= '0;
      bus.out_tag <= '0;
      bus.out_dbz <= 1'b0;
      bus.out_ovf <= 1'b0;
    end else if (accept) begin
      state_q <= bus.in_b == '0 ? OUT : CALC;
      sign_q <= bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1];
      b_q <= abs_b;
      r_q <= '0;
      qd_q <= P'(abs_a) << (FBITS + 1);
      cnt_q <= '0;
      tag_q <= bus.in_tag;
      bus.out_valid <= bus.in_b == '0;
      bus.out_val <= dbz_val;
      bus.out_tag <= bus.in_tag;
      bus.out_dbz <= bus.in_b == '0;
      bus.out_ovf <= 1'b0;
    end else begin
      case (state_q)
        CALC: begin
          r_q <= r_d;
          qd_q <= qd_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(C - 1)) state_q <= ROUND;
        end
        ROUND: begin
          state_q <= OUT;
          bus.out_valid <= 1'b1;
          bus.out_val <= ovf ? ovf_val : res;
          bus.out_tag <= tag_q;
          bus.out_dbz <= 1'b0;
          bus.out_ovf <= ovf;
        end
        OUT: if (bus.out_ready) begin
          state_q <= IDLE;
          bus.out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fxp_div_stream.sv
// tb_fxp_div_stream: scoreboard bench for fxp_div_stream at WIDTH=16, FBITS=8, BPC=4.
module tb_fxp_div_stream;
  localparam int BPC = 4;
  localparam int C = (25 + BPC - 1) / BPC;
`ifdef FXP_DIV_SAT_EN
  localparam logic [15:0] OVP = 16'h7fff;
  localparam logic [15:0] OVN = 16'h8000;
`else
  localparam logic [15:0] OVP = 16'h0000;
  localparam logic [15:0] OVN = 16'h0000;
`endif
  typedef struct packed {logic [15:0] val; logic [3:0] tag; logic dbz; logic ovf;} res_t;
  logic clk = 0;
  logic rst_n = 0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int lat;
  int acc[4];
  res_t sb[$];
  fxp_div_stream_if #(.WIDTH(16), .TAGW(4)) bus ();
  fxp_div_stream #(.WIDTH(16), .FBITS(8), .BPC(BPC), .TAGW(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask
  function automatic res_t model(logic [15:0] a, logic [15:0] b, logic [3:0] tag);
    longint ma, mb, g, r, m;
    logic s, ov;
    logic [15:0] v;
    s = a[15] ^ b[15];
    ma = a[15] ? 65536 - longint'(a) : longint'(a);
    mb = b[15] ? 65536 - longint'(b) : longint'(b);
    if (b == 16'h0) return {a[15] ? OVN : (a != 16'h0 ? OVP : 16'h0), tag, 2'b10};
    g = (ma << 9) / mb;
    r = (ma << 9) % mb;
    m = g / 2 + longint'((g % 2 == 1) && ((g / 2) % 2 == 1 || r != 0));
    ov = s ? m > 32768 : m > 32767;
    v = ov ? (s ? OVN : OVP) : (s ? 16'(-m) : 16'(m));
    return {v, tag, 1'b0, ov};
  endfunction
  always @(negedge clk) if (rst_n && bus.out_valid && bus.out_ready) begin
    res_t e;
    chk("out_expected", 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("out_val", bus.out_val, e.val);
      chk("out_tag", bus.out_tag, e.tag);
      chk("out_dbz", bus.out_dbz, e.dbz);
      chk("out_ovf", bus.out_ovf, e.ovf);
    end
  end
  task automatic req(logic [15:0] a, logic [15:0] b, logic [3:0] tag, res_t e);
    int n = 0;
    bus.in_valid = 1;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_tag = tag;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 32'(bus.in_ready), 1);
    if (!bus.in_ready) begin
      bus.in_valid = 0;
      return;
    end
    @(posedge clk);
    sb.push_back(e);
    #1;
    bus.in_valid = 0;
    acc_cyc = cyc;
  endtask
  task automatic wait_out(output int n);
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic run(logic [15:0] a, logic [15:0] b, logic [3:0] tag, res_t e, int exp_lat);
    req(a, b, tag, e);
    wait_out(lat);
    chk("latency", lat, exp_lat);
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask
  initial begin
    bus.in_valid = 0;
    bus.in_a = 0;
    bus.in_b = 0;
    bus.in_tag = 0;
    bus.out_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_val", bus.out_val, 0);
    chk("rst_out_tag", bus.out_tag, 0);
    chk("rst_flags", {bus.out_dbz, bus.out_ovf}, 0);
    chk("rst_busy", bus.busy, 0);
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("idle_in_ready", bus.in_ready, 1);
    run(16'h0180, 16'h0080, 4'd1, {16'h0300, 4'd1, 2'b00}, C + 1);
    run(16'hff00, 16'h0300, 4'd2, {16'hffab, 4'd2, 2'b00}, C + 1);
    run(16'h0001, 16'h0200, 4'd3, {16'h0000, 4'd3, 2'b00}, C + 1);
    run(16'h0003, 16'h0200, 4'd4, {16'h0002, 4'd4, 2'b00}, C + 1);
    run(16'hfffd, 16'h0200, 4'd5, {16'hfffe, 4'd5, 2'b00}, C + 1);
    run(16'h8000, 16'h0100, 4'd6, {16'h8000, 4'd6, 2'b00}, C + 1);
    run(16'h8000, 16'hff00, 4'd7, {OVP, 4'd7, 2'b01}, C + 1);
    run(16'h0100, 16'h0000, 4'd5, {OVP, 4'd5, 2'b10}, 0);
    run(16'hff00, 16'h0000, 4'd8, {OVN, 4'd8, 2'b10}, 0);
    run(16'h0000, 16'h0000, 4'd9, {16'h0000, 4'd9, 2'b10}, 0);
    drain();
    // hold: result must stay put and a stray request must be ignored
    @(posedge clk);
    #1 bus.out_ready = 0;
    run(16'h0200, 16'h0300, 4'd7, {16'h00ab, 4'd7, 2'b00}, C + 1);
    bus.in_valid = 1;
    bus.in_a = 16'h0001;
    bus.in_b = 16'h0001;
    bus.in_tag = 4'd9;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_val", bus.out_val, 16'h00ab);
      chk("hold_tag", bus.out_tag, 4'd7);
      chk("hold_in_ready", bus.in_ready, 0);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 0;
    bus.out_ready = 1;
    drain();
    @(negedge clk);
    chk("after_hold_busy", bus.busy, 0);
    chk("after_hold_valid", bus.out_valid, 0);
    req(16'h0400, 16'h0300, 4'd1, model(16'h0400, 16'h0300, 4'd1));
    acc[0] = acc_cyc;
    req(16'hf000, 16'h0700, 4'd2, model(16'hf000, 16'h0700, 4'd2));
    acc[1] = acc_cyc;
    req(16'h7fff, 16'h0001, 4'd3, model(16'h7fff, 16'h0001, 4'd3));
    acc[2] = acc_cyc;
    req(16'h1234, 16'hfedc, 4'd4, model(16'h1234, 16'hfedc, 4'd4));
    acc[3] = acc_cyc;
    for (int i = 1; i < 4; i++) chk("b2b_spacing", acc[i] - acc[i-1], C + 2);
    drain();
    req(16'h0180, 16'h0080, 4'd3, {16'h0300, 4'd3, 2'b00});
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_val", bus.out_val, 0);
    chk("mid_rst_tag", bus.out_tag, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < C + 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_valid", bus.out_valid, 0);
    end
    run(16'hff00, 16'h0300, 4'd6, {16'hffab, 4'd6, 2'b00}, C + 1);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
